// File: rtl/fmt_rx_if.sv
// Formatter-to-receiver packet bus: request/grant arbitration plus framed data words.
interface fmt_rx_if;
  logic        fmt_req_i;
  logic [1:0]  fmt_chid_i;
  logic [5:0]  fmt_length_i;
  logic        fmt_grant_o;
  logic        fmt_start_i;
  logic [31:0] fmt_data_i;
  logic        fmt_end_i;

  modport master (
    output fmt_req_i, fmt_chid_i, fmt_length_i, fmt_start_i, fmt_data_i, fmt_end_i,
    input  fmt_grant_o
  );

  modport slave (
    input  fmt_req_i, fmt_chid_i, fmt_length_i, fmt_start_i, fmt_data_i, fmt_end_i,
    output fmt_grant_o
  );
endinterface

// File: rtl/fmt_rx.sv
// Formatter packet receiver: grants space-checked requests, stores words in a FIFO,
// validates length/channel and keeps saturating per-channel statistics behind a cmd port.
module fmt_rx #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  fmt_rx_if.slave      fmt,
  input  logic         rd_en_i,
  output logic [31:0]  rd_data_o,
  output logic         rd_vld_o,
  output logic         rd_empty_o,
  input  logic [1:0]   cmd_i,
  input  logic [5:0]   cmd_addr_i,
  input  logic [31:0]  cmd_data_i,
  output logic [31:0]  cmd_data_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = 8;
  localparam int unsigned EW = CNT_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, WAIT_START = 2'd2, RECV = 2'd3} state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_chid, w_chid_nxt;
  logic [5:0]        r_len, w_len_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic              r_grant;
  logic              w_wr_en, w_close, w_close_good;
  logic [1:0]        w_err_inc;

  logic [31:0]       r_mem [DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [LW-1:0]     r_level, w_level_nxt, w_free;
  logic              r_empty, r_rd_vld, w_rd_fire;
  logic [31:0]       r_rd_data;

  logic [CNT_W-1:0]  r_pkt_cnt [3];
  logic [CNT_W-1:0]  r_err_cnt;
  logic [EW-1:0]     w_err_sum;
  logic              w_clr;
  logic [31:0]       r_cmd_data, w_rd_reg;
  logic              w_unused;

  assign w_free      = LW'(DEPTH) - r_level;
  assign w_rd_fire   = rd_en_i && (r_level != '0);
  assign w_level_nxt = r_level + LW'(w_wr_en) - LW'(w_rd_fire);
  assign w_unused    = ^cmd_data_i[31:1];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= IDLE;
      r_chid  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_grant <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_chid  <= w_chid_nxt;
      r_len   <= w_len_nxt;
      r_cnt   <= w_cnt_nxt;
      r_grant <= (w_state_nxt == GRANT);
    end
  end

  // Sequencing, FIFO write gating, packet close and error events.
  always_comb begin
    w_state_nxt = r_state;
    w_chid_nxt  = r_chid;
    w_len_nxt   = r_len;
    w_cnt_nxt   = r_cnt;
    w_wr_en     = 1'b0;
    w_close     = 1'b0;
    w_err_inc   = 2'd0;
    case (r_state)
      IDLE: begin
        if (fmt.fmt_start_i) w_err_inc = 2'd1;
        if (fmt.fmt_req_i && (w_free >= LW'(fmt.fmt_length_i))) begin
          w_chid_nxt  = fmt.fmt_chid_i;
          w_len_nxt   = fmt.fmt_length_i;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (fmt.fmt_start_i) w_err_inc = 2'd1;
        w_state_nxt = WAIT_START;
      end
      WAIT_START: begin
        if (fmt.fmt_start_i) begin
          w_wr_en     = 1'b1;
          w_cnt_nxt   = CW'(1);
          w_state_nxt = RECV;
          if (fmt.fmt_end_i) begin
            w_close     = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        // Words past the granted length are counted but not stored.
        w_wr_en = (r_cnt < CW'(r_len));
        if (r_cnt != '1) w_cnt_nxt = r_cnt + CW'(1);
        if (fmt.fmt_start_i) w_err_inc = 2'd1;
        if (fmt.fmt_end_i) begin
          w_close     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
    endcase
    w_close_good = w_close && (w_cnt_nxt == CW'(r_len)) && (r_chid != 2'd3);
    if (w_close && !w_close_good) w_err_inc = w_err_inc + 2'd1;
  end

  assign fmt.fmt_grant_o = r_grant;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[r_wptr] <= fmt.fmt_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_empty   <= 1'b1;
      r_rd_vld  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      if (w_wr_en) r_wptr <= r_wptr + AW'(1);
      if (w_rd_fire) begin
        r_rptr    <= r_rptr + AW'(1);
        r_rd_data <= r_mem[r_rptr];
      end
      r_rd_vld <= w_rd_fire;
      r_level  <= w_level_nxt;
      r_empty  <= (w_level_nxt == '0);
    end
  end

  assign w_clr     = (cmd_i == 2'd2) && (cmd_addr_i == 6'h14) && cmd_data_i[0];
  assign w_err_sum = {1'b0, r_err_cnt} + EW'(w_err_inc);

  // Saturating statistics; a clear overrides any same-cycle increment.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int c = 0; c < 3; c++) r_pkt_cnt[c] <= '0;
      r_err_cnt <= '0;
    end else if (w_clr) begin
      for (int c = 0; c < 3; c++) r_pkt_cnt[c] <= '0;
      r_err_cnt <= '0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (w_close_good && (r_chid == 2'(c)) && (r_pkt_cnt[c] != '1))
          r_pkt_cnt[c] <= r_pkt_cnt[c] + CNT_W'(1);
      end
      r_err_cnt <= w_err_sum[CNT_W] ? '1 : w_err_sum[CNT_W-1:0];
    end
  end

  always_comb begin
    w_rd_reg = '0;
    case (cmd_addr_i)
      6'h00:   w_rd_reg = 32'(r_pkt_cnt[0]);
      6'h04:   w_rd_reg = 32'(r_pkt_cnt[1]);
      6'h08:   w_rd_reg = 32'(r_pkt_cnt[2]);
      6'h0C:   w_rd_reg = 32'(r_err_cnt);
      6'h10:   w_rd_reg = 32'(r_level);
      6'h14:   w_rd_reg = 32'(r_state);
      default: w_rd_reg = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)           r_cmd_data <= '0;
    else if (cmd_i == 2'd1) r_cmd_data <= w_rd_reg;
  end

  assign rd_data_o  = r_rd_data;
  assign rd_vld_o   = r_rd_vld;
  assign rd_empty_o = r_empty;
  assign cmd_data_o = r_cmd_data;
endmodule
